loopback_tester: RTL and testbench

- Self-checking pattern generator and checker that drives the other end of the tile loopback path.
- Emits a stream of 8-bit stimulus vectors toward the loopback user module, samples the returned 8 bits after a fixed round-trip latency, and compares them with the loopback transfer function: rx = {&t[7:4], {7{t[0]}}}.
- Reports pass/fail, a saturating error count and the first failing vector, for board bring-up and production test.

---
 rtl/loopback_pkg.sv | 33 +++
 rtl/lfsr8.sv | 33 +++
 rtl/loopback_tester.sv | 169 ++++++++++++++++
 tb/tb_loopback_tester.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/loopback_pkg.sv
// -----------------------------------------------------------------------------
// loopback_pkg
// Shared types and helpers for the loopback tester and its LFSR.
//   state_t      : tester FSM states (IDLE, RUN, DRAIN, DONE)
//   LFSR_TAPS    : feedback mask for x^8+x^6+x^5+x^4+1
//   LFSR_SEED    : value loaded at the start of every LFSR run
//   expected_rx  : transfer function of the loopback user module
//   lfsr_step    : one Fibonacci LFSR advance
// -----------------------------------------------------------------------------
package loopback_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [7:0] LFSR_TAPS = 8'hB8;
   localparam logic [7:0] LFSR_SEED = 8'h01;

   // The loopback module returns the AND of the top nibble in bit 7 and
   // bit 0 replicated into bits 6..0.
   function automatic logic [7:0] expected_rx(input logic [7:0] t);
      return {&t[7:4], {7{t[0]}}};
   endfunction

   // Shift left, feedback bit is the parity of the tapped bits (7,5,4,3).
   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      return {s[6:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/lfsr8.sv
// -----------------------------------------------------------------------------
// lfsr8
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), period 255 from any nonzero seed.
//   clk, rst  : clock, asynchronous active-high reset (state -> LFSR_SEED)
//   load      : load seed (has priority over advance)
//   seed      : value to load
//   advance   : step the register once
//   state     : current LFSR value
// -----------------------------------------------------------------------------
module lfsr8
   import loopback_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] seed,
   input  logic       advance,
   output logic [7:0] state
);

   // NOTE: sequential state is always written with non-blocking assignments so
   // every register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= LFSR_SEED;
      end else if (load) begin
         state <= seed;
      end else if (advance) begin
         state <= lfsr_step(state);
      end
   end

endmodule

// File: rtl/loopback_tester.sv
// -----------------------------------------------------------------------------
// loopback_tester
// Drives a stream of 8-bit vectors into the loopback path, compares each
// returned value LAT cycles later with the loopback transfer function and
// reports pass/fail, a saturating error count and the first failing vector.
//   clk, rst        : clock, asynchronous active-high reset
//   start           : one-cycle run request (ignored while busy)
//   mode            : 0 = counting pattern, 1 = LFSR pattern (sampled at start)
//   n_vec           : number of vectors in the run (sampled at start)
//   tx_data         : registered stimulus, 0 outside RUN
//   rx_data         : returned loopback value, synchronous to clk
//   busy            : run in progress (RUN or DRAIN)
//   done            : sticky completion flag
//   pass            : valid with done, 1 when no mismatch was seen
//   err_cnt         : saturating mismatch count
//   first_err_idx   : index of the first mismatching vector
//   first_err_rx    : rx_data seen at the first mismatch
// -----------------------------------------------------------------------------
module loopback_tester
   import loopback_pkg::*;
#(
   parameter int N_VEC_W = 16,
   parameter int LAT     = 2,
   parameter int ERR_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               mode,
   input  logic [N_VEC_W-1:0] n_vec,
   output logic [7:0]         tx_data,
   input  logic [7:0]         rx_data,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [ERR_W-1:0]   err_cnt,
   output logic [N_VEC_W-1:0] first_err_idx,
   output logic [7:0]         first_err_rx
);

   state_t               state_q, state_d;
   logic                 mode_q;
   logic [N_VEC_W-1:0]   n_vec_q;
   logic [N_VEC_W-1:0]   vec_idx;      // index of the vector currently on tx_data
   logic [N_VEC_W-1:0]   idx_inc;
   logic [3:0]           drain_cnt;
   logic                 first_seen;
   logic [7:0]           lfsr_q;

   // Check pipeline: stage 0 captures the vector on tx_data, stage LAT-1 is
   // compared against rx_data on the following edge.
   logic                 pipe_valid [LAT];
   logic [N_VEC_W-1:0]   pipe_idx   [LAT];
   logic [7:0]           pipe_exp   [LAT];

   logic                 accept;
   logic                 last_vec;
   logic                 drain_end;
   logic                 mismatch;
   logic [ERR_W-1:0]     err_nxt;

   assign accept    = start && (state_q == IDLE || state_q == DONE);
   assign last_vec  = (vec_idx == n_vec_q - N_VEC_W'(1));
   assign drain_end = (drain_cnt == 4'(LAT - 1));
   assign idx_inc   = vec_idx + N_VEC_W'(1);
   assign mismatch  = pipe_valid[LAT-1] && (rx_data != pipe_exp[LAT-1]);
   assign err_nxt   = (mismatch && err_cnt != '1) ? err_cnt + ERR_W'(1) : err_cnt;

   assign busy = (state_q == RUN) || (state_q == DRAIN);
   assign done = (state_q == DONE);

   lfsr8 u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .load    (accept),
      .seed    (LFSR_SEED),
      .advance (state_q == RUN && !last_vec),
      .state   (lfsr_q)
   );

   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE: if (start) state_d = (n_vec == '0) ? DONE : RUN;
         RUN:        if (last_vec) state_d = DRAIN;
         DRAIN:      if (drain_end) state_d = DONE;
         default:    state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q        <= 1'b0;
         n_vec_q       <= '0;
         vec_idx       <= '0;
         drain_cnt     <= '0;
         first_seen    <= 1'b0;
         tx_data       <= '0;
         pass          <= 1'b0;
         err_cnt       <= '0;
         first_err_idx <= '0;
         first_err_rx  <= '0;
         // NOTE: the check pipeline is cleared on reset so no stale entry can
         // be compared after a mid-run reset.
         for (int i = 0; i < LAT; i++) begin
            pipe_valid[i] <= 1'b0;
            pipe_idx[i]   <= '0;
            pipe_exp[i]   <= '0;
         end
      end else begin
         // tx_data is only a real vector while in RUN.
         pipe_valid[0] <= (state_q == RUN);
         pipe_idx[0]   <= vec_idx;
         pipe_exp[0]   <= expected_rx(tx_data);
         for (int i = 1; i < LAT; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_idx[i]   <= pipe_idx[i-1];
            pipe_exp[i]   <= pipe_exp[i-1];
         end

         err_cnt <= err_nxt;
         if (mismatch && !first_seen) begin
            first_seen    <= 1'b1;
            first_err_idx <= pipe_idx[LAT-1];
            first_err_rx  <= rx_data;
         end

         unique case (state_q)
            RUN: begin
               if (last_vec) begin
                  tx_data   <= '0;
                  drain_cnt <= '0;
               end else begin
                  vec_idx <= idx_inc;
                  tx_data <= mode_q ? lfsr_step(lfsr_q) : idx_inc[7:0];
               end
            end
            DRAIN: begin
               drain_cnt <= drain_cnt + 4'd1;
               // The last vector is compared on this same edge, so use err_nxt.
               if (drain_end) pass <= (err_nxt == '0);
            end
            default: ;
         endcase

         if (accept) begin
            mode_q        <= mode;
            n_vec_q       <= n_vec;
            vec_idx       <= '0;
            err_cnt       <= '0;
            first_seen    <= 1'b0;
            first_err_idx <= '0;
            first_err_rx  <= '0;
            pass          <= (n_vec == '0);
            tx_data       <= (n_vec != '0 && mode) ? LFSR_SEED : 8'h00;
         end
      end
   end

endmodule

// File: tb/tb_loopback_tester.sv
// -----------------------------------------------------------------------------
// tb_loopback_tester
// Randomized and directed runs of loopback_tester against a loopback-path
// model with selectable faults; expected stimulus, status timing and error
// results come from a reference model built from the pattern rules.
// -----------------------------------------------------------------------------
module tb_loopback_tester;

   localparam int N_VEC_W = 16;
   localparam int LAT     = 2;
   localparam int ERR_W   = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               mode;
   logic [N_VEC_W-1:0] n_vec;
   logic [7:0]         tx_data;
   logic [7:0]         rx_data;
   logic               busy;
   logic               done;
   logic               pass;
   logic [ERR_W-1:0]   err_cnt;
   logic [N_VEC_W-1:0] first_err_idx;
   logic [7:0]         first_err_rx;

   int n_checks = 0;
   int n_pass   = 0;

   // Fault selection for the loopback model:
   // 0 ideal, 1 bit7 stuck 0, 2 bit0 stuck 1, 3 forced 0x55, 4 random xor on a residue class
   int         fault_sel = 0;
   int         rnd_mod   = 3;
   int         rnd_res   = 0;
   logic [7:0] rnd_mask  = 8'h01;

   always #5 clk = ~clk;

   loopback_tester #(
      .N_VEC_W (N_VEC_W),
      .LAT     (LAT),
      .ERR_W   (ERR_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .mode          (mode),
      .n_vec         (n_vec),
      .tx_data       (tx_data),
      .rx_data       (rx_data),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .err_cnt       (err_cnt),
      .first_err_idx (first_err_idx),
      .first_err_rx  (first_err_rx)
   );

   function automatic logic [7:0] ideal_rx(input logic [7:0] t);
      logic [7:0] r;
      r = 8'h00;
      if (t >= 8'hF0) r = r | 8'h80;
      if (t % 2 == 1) r = r | 8'h7F;
      return r;
   endfunction

   function automatic logic [7:0] line_rx(input logic [7:0] t);
      logic [7:0] r;
      r = ideal_rx(t);
      case (fault_sel)
         1:       return r & 8'h7F;
         2:       return r | 8'h01;
         3:       return 8'h55;
         4:       return (int'(t) % rnd_mod == rnd_res) ? (r ^ rnd_mask) : r;
         default: return r;
      endcase
   endfunction

   // Loopback path: LAT register stages from tx_data to rx_data.
   logic [7:0] lb [LAT];
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) lb[i] <= 8'h00;
      end else begin
         lb[0] <= line_rx(tx_data);
         for (int i = 1; i < LAT; i++) lb[i] <= lb[i-1];
      end
   end
   assign rx_data = lb[LAT-1];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // One run: build the expected vector list and error results, then follow
   // the run cycle by cycle. glitch > 1 pulses a bogus start on that cycle.
   task automatic run_test(input logic m, input int n, input int f, input int glitch);
      logic [7:0] vec [$];
      logic [7:0] s;
      logic [7:0] got_rx;
      int         exp_err;
      int         exp_first_idx;
      logic [7:0] exp_first_rx;
      bit         seen [256];
      int         distinct;
      logic [7:0] exp_tx;

      fault_sel = f;
      s = 8'h01;
      for (int k = 0; k < n; k++) begin
         vec.push_back(m ? s : 8'(k));
         s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
      end

      exp_err       = 0;
      exp_first_idx = 0;
      exp_first_rx  = 8'h00;
      for (int k = 0; k < n; k++) begin
         got_rx = line_rx(vec[k]);
         if (got_rx != ideal_rx(vec[k])) begin
            if (exp_err == 0) begin
               exp_first_idx = k;
               exp_first_rx  = got_rx;
            end
            exp_err++;
         end
      end
      if (exp_err > 255) exp_err = 255;

      for (int i = 0; i < 256; i++) seen[i] = 1'b0;

      @(negedge clk);
      start = 1'b1;
      mode  = m;
      n_vec = N_VEC_W'(n);
      @(posedge clk);
      for (int c = 1; c <= n + LAT + 2; c++) begin
         @(negedge clk);
         start = (c == glitch);
         if (c == glitch) begin
            mode  = ~m;
            n_vec = 16'd3;
         end
         exp_tx = (c <= n) ? vec[c-1] : 8'h00;
         check($sformatf("tx m%0d n%0d c%0d", m, n, c), tx_data, exp_tx);
         check($sformatf("busy n%0d c%0d", n, c), busy, (n > 0 && c <= n + LAT));
         check($sformatf("done n%0d c%0d", n, c), done, (n == 0 || c >= n + LAT + 1));
         if (c <= n) seen[tx_data] = 1'b1;
      end
      start = 1'b0;

      check($sformatf("err_cnt n%0d f%0d", n, f), err_cnt, exp_err);
      check($sformatf("pass n%0d f%0d", n, f), pass, (exp_err == 0));
      check($sformatf("first_err_idx n%0d f%0d", n, f), first_err_idx, exp_first_idx);
      check($sformatf("first_err_rx n%0d f%0d", n, f), first_err_rx, exp_first_rx);

      if (m && n == 255) begin
         distinct = 0;
         for (int i = 1; i < 256; i++) if (seen[i]) distinct++;
         check("lfsr_distinct_nonzero", distinct, 255);
         check("lfsr_zero_absent", seen[0], 0);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " tx"}, tx_data, 0);
      check({tag, " busy"}, busy, 0);
      check({tag, " done"}, done, 0);
      check({tag, " pass"}, pass, 0);
      check({tag, " err_cnt"}, err_cnt, 0);
      check({tag, " first_err_idx"}, first_err_idx, 0);
      check({tag, " first_err_rx"}, first_err_rx, 0);
   endtask

   // Start a faulty run and hit it with reset on cycle 5.
   task automatic reset_mid_run();
      fault_sel = 3;
      @(negedge clk);
      start = 1'b1;
      mode  = 1'b1;
      n_vec = 16'd50;
      @(posedge clk);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      @(negedge clk);
      check("pre_reset busy", busy, 1);
      check("pre_reset err_cnt", err_cnt, 2);
      #1 rst = 1'b1;
      #1 check_all_zero("mid_run_reset");
      @(negedge clk);
      check_all_zero("held_reset");
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("after_reset idle");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic rm;
      int   rn;
      int   rf;

      rst   = 1'b1;
      start = 1'b0;
      mode  = 1'b0;
      n_vec = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      run_test(1'b0, 16,   0, 0);
      run_test(1'b0, 256,  1, 0);
      run_test(1'b0, 4,    2, 0);
      run_test(1'b1, 255,  0, 0);
      run_test(1'b0, 1000, 3, 0);
      run_test(1'b0, 0,    0, 0);
      run_test(1'b1, 40,   0, 5);
      reset_mid_run();
      run_test(1'b0, 20,   0, 0);

      repeat (8) begin
         rm       = 1'($urandom_range(0, 1));
         rn       = int'($urandom_range(1, 300));
         rf       = int'($urandom_range(0, 4));
         rnd_mod  = int'($urandom_range(2, 9));
         rnd_res  = int'($urandom_range(0, rnd_mod - 1));
         rnd_mask = 8'($urandom_range(1, 255));
         run_test(rm, rn, rf, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
